// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with load-use stall detection and bubble counter
module id_ex_pipe_reg #(
  parameter int XLEN = 32,
  parameter int REGW = 5,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic            id_ALUSrc,
  input  logic            id_MemtoReg,
  input  logic            id_RegWrite,
  input  logic            id_MemRead,
  input  logic            id_MemWrite,
  input  logic            id_Branch,
  input  logic            id_jump,
  input  logic [1:0]      id_Aluop,
  input  logic [3:0]      id_funct,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic            flush,
  output logic            stall_out,
  output logic            ex_valid,
  output logic            ex_ALUSrc,
  output logic            ex_MemtoReg,
  output logic            ex_RegWrite,
  output logic            ex_MemRead,
  output logic            ex_MemWrite,
  output logic            ex_Branch,
  output logic            ex_jump,
  output logic [1:0]      ex_Aluop,
  output logic [3:0]      ex_funct,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [REGW-1:0] ex_rs1,
  output logic [REGW-1:0] ex_rs2,
  output logic [REGW-1:0] ex_rd,
  output logic [CNTW-1:0] bubble_cnt
);

  logic            valid_q,    valid_d;
  logic            alusrc_q,   alusrc_d;
  logic            memtoreg_q, memtoreg_d;
  logic            regwrite_q, regwrite_d;
  logic            memread_q,  memread_d;
  logic            memwrite_q, memwrite_d;
  logic            branch_q,   branch_d;
  logic            jump_q,     jump_d;
  logic [1:0]      aluop_q,    aluop_d;
  logic [3:0]      funct_q,    funct_d;
  logic [XLEN-1:0] pc_q,       pc_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [XLEN-1:0] imm_q,      imm_d;
  logic [REGW-1:0] rs1_q,      rs1_d;
  logic [REGW-1:0] rs2_q,      rs2_d;
  logic [REGW-1:0] rd_q,       rd_d;
  logic [CNTW-1:0] cnt_q,      cnt_d;

  logic hz;
  logic bub;
  logic cnt_inc;

  // A load in EX whose destination is read by the ID instruction; x0 never conflicts.
  always_comb begin
    hz = valid_q & memread_q & (rd_q != '0) &
         ((id_uses_rs1 & (id_rs1 == rd_q)) | (id_uses_rs2 & (id_rs2 == rd_q)));
    stall_out = ~reset & id_valid & hz & ~flush;
    bub       = flush | stall_out | ~id_valid;
    cnt_inc   = id_valid & (flush | stall_out);
  end

  // Bubbles load constant zeros so X on wrong-path controller outputs cannot propagate.
  always_comb begin
    valid_d    = 1'b0;
    alusrc_d   = 1'b0;
    memtoreg_d = 1'b0;
    regwrite_d = 1'b0;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    branch_d   = 1'b0;
    jump_d     = 1'b0;
    aluop_d    = '0;
    funct_d    = '0;
    pc_d       = '0;
    rs1_data_d = '0;
    rs2_data_d = '0;
    imm_d      = '0;
    rs1_d      = '0;
    rs2_d      = '0;
    rd_d       = '0;
    if (!bub) begin
      valid_d    = 1'b1;
      alusrc_d   = id_ALUSrc;
      memtoreg_d = id_MemtoReg;
      regwrite_d = id_RegWrite;
      memread_d  = id_MemRead;
      memwrite_d = id_MemWrite;
      branch_d   = id_Branch;
      jump_d     = id_jump;
      aluop_d    = id_Aluop;
      funct_d    = id_funct;
      pc_d       = id_pc;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_inc && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      alusrc_q   <= 1'b0;
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      branch_q   <= 1'b0;
      jump_q     <= 1'b0;
      aluop_q    <= '0;
      funct_q    <= '0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      alusrc_q   <= alusrc_d;
      memtoreg_q <= memtoreg_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      branch_q   <= branch_d;
      jump_q     <= jump_d;
      aluop_q    <= aluop_d;
      funct_q    <= funct_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    ex_valid    = valid_q;
    ex_ALUSrc   = alusrc_q;
    ex_MemtoReg = memtoreg_q;
    ex_RegWrite = regwrite_q;
    ex_MemRead  = memread_q;
    ex_MemWrite = memwrite_q;
    ex_Branch   = branch_q;
    ex_jump     = jump_q;
    ex_Aluop    = aluop_q;
    ex_funct    = funct_q;
    ex_pc       = pc_q;
    ex_rs1_data = rs1_data_q;
    ex_rs2_data = rs2_data_q;
    ex_imm      = imm_q;
    ex_rs1      = rs1_q;
    ex_rs2      = rs2_q;
    ex_rd       = rd_q;
    bubble_cnt  = cnt_q;
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - directed self-checking bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic        id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch, id_jump;
  logic [1:0]  id_Aluop;
  logic [3:0]  id_funct;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2;
  logic        flush;
  logic        stall_out;
  logic        ex_valid;
  logic        ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_jump;
  logic [1:0]  ex_Aluop;
  logic [3:0]  ex_funct;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [15:0] bubble_cnt;

  int n_checks;
  int n_fail;

  id_ex_pipe_reg #(.XLEN(32), .REGW(5), .CNTW(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_ALUSrc(id_ALUSrc), .id_MemtoReg(id_MemtoReg), .id_RegWrite(id_RegWrite),
    .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_Branch(id_Branch),
    .id_jump(id_jump), .id_Aluop(id_Aluop), .id_funct(id_funct),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .flush(flush),
    .stall_out(stall_out), .ex_valid(ex_valid),
    .ex_ALUSrc(ex_ALUSrc), .ex_MemtoReg(ex_MemtoReg), .ex_RegWrite(ex_RegWrite),
    .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_Branch(ex_Branch),
    .ex_jump(ex_jump), .ex_Aluop(ex_Aluop), .ex_funct(ex_funct),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_ctrl(input logic [6:0] c, input logic [1:0] op);
    {id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch, id_jump} = c;
    id_Aluop = op;
  endtask

  task automatic drive_regs(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                            input logic u2, input logic [4:0] rd);
    id_rs1 = rs1; id_uses_rs1 = u1;
    id_rs2 = rs2; id_uses_rs2 = u2;
    id_rd  = rd;
  endtask

  // add rd,rs1,rs2: RegWrite only, Aluop R-type
  task automatic drive_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    id_valid = 1'b1;
    drive_ctrl(7'b0010000, 2'b10);
    id_funct = 4'b0000;
    drive_regs(rs1, 1'b1, rs2, 1'b1, rd);
  endtask

  // lw rd,0(rs1): ALUSrc, MemtoReg, RegWrite, MemRead
  task automatic drive_lw(input logic [4:0] rd, input logic [4:0] rs1);
    id_valid = 1'b1;
    drive_ctrl(7'b1111000, 2'b00);
    id_funct = 4'b0010;
    drive_regs(rs1, 1'b1, 5'd0, 1'b0, rd);
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    flush    = 1'b0;
    id_pc = 32'h0; id_rs1_data = 32'h0; id_rs2_data = 32'h0; id_imm = 32'h0;

    // reset held with random ID inputs
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      id_valid = 1'b1;
      drive_ctrl(7'($urandom), 2'($urandom));
      id_funct = 4'($urandom);
      id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      drive_regs(5'($urandom), 1'b1, 5'($urandom), 1'b1, 5'($urandom));
    end
    #1;
    check("rst_valid", ex_valid, 0);
    check("rst_ctrl", {ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_jump, ex_Aluop}, 0);
    check("rst_data", {ex_pc, ex_imm}, 0);
    check("rst_regs", {ex_rs1, ex_rs2, ex_rd, ex_funct}, 0);
    check("rst_stall", stall_out, 0);
    check("rst_cnt", bubble_cnt, 0);
    @(negedge clk);
    reset = 1'b0;

    // add x3,x1,x2
    drive_add(5'd3, 5'd1, 5'd2);
    id_pc = 32'h0000_0100; id_rs1_data = 32'h1111_2222; id_rs2_data = 32'h3333_4444; id_imm = 32'h0;
    #1 check("add_stall", stall_out, 0);
    step();
    check("add_regwrite", ex_RegWrite, 1);
    check("add_aluop", ex_Aluop, 2'b10);
    check("add_rd", ex_rd, 3);
    check("add_valid", ex_valid, 1);
    check("add_pc", ex_pc, 32'h0000_0100);
    check("add_rs1_data", ex_rs1_data, 32'h1111_2222);

    // lw x5 then add x6,x5,x7: one-cycle stall
    drive_lw(5'd5, 5'd1);
    id_pc = 32'h0000_0104; id_imm = 32'h0000_0010;
    step();
    check("lw_memread", ex_MemRead, 1);
    check("lw_imm", ex_imm, 32'h10);
    drive_add(5'd6, 5'd5, 5'd7);
    id_pc = 32'h0000_0108; id_imm = 32'h0;
    #1 check("lu_stall", stall_out, 1);
    step();
    check("lu_bub_valid", ex_valid, 0);
    check("lu_bub_memread", ex_MemRead, 0);
    check("lu_bub_rd", ex_rd, 0);
    check("lu_cnt", bubble_cnt, 1);
    #1 check("lu_stall_drop", stall_out, 0);
    step();
    check("lu_add_valid", ex_valid, 1);
    check("lu_add_rd", ex_rd, 6);
    check("lu_add_rs1", ex_rs1, 5);
    check("lu_add_pc", ex_pc, 32'h0000_0108);
    check("lu_cnt_hold", bubble_cnt, 1);

    // lw x0 then add reading x0: no hazard
    drive_lw(5'd0, 5'd2);
    step();
    check("x0_memread", ex_MemRead, 1);
    drive_add(5'd8, 5'd0, 5'd0);
    #1 check("x0_stall", stall_out, 0);
    step();
    check("x0_valid", ex_valid, 1);
    check("x0_rd", ex_rd, 8);
    check("x0_cnt", bubble_cnt, 1);

    // hazard and flush together
    drive_lw(5'd5, 5'd1);
    step();
    drive_add(5'd6, 5'd5, 5'd7);
    flush = 1'b1;
    #1 check("fl_stall", stall_out, 0);
    step();
    check("fl_valid", ex_valid, 0);
    check("fl_cnt", bubble_cnt, 2);

    // X controller outputs under flush
    id_valid = 1'b1;
    {id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch, id_jump} = 'x;
    id_Aluop = 'x;
    id_rd = 5'd9;
    step();
    check("fx_regwrite", ex_RegWrite, 0);
    check("fx_memwrite", ex_MemWrite, 0);
    check("fx_rd", ex_rd, 0);
    check("fx_cnt", bubble_cnt, 3);

    // idle cycle is not counted
    flush = 1'b0;
    id_valid = 1'b0;
    drive_ctrl(7'b0010000, 2'b10);
    step();
    check("idle_valid", ex_valid, 0);
    check("idle_cnt", bubble_cnt, 3);

    // reset in the middle of a stall
    drive_lw(5'd5, 5'd1);
    step();
    drive_add(5'd6, 5'd5, 5'd7);
    #1 check("mr_stall_pre", stall_out, 1);
    reset = 1'b1;
    #1;
    check("mr_stall", stall_out, 0);
    check("mr_valid", ex_valid, 0);
    check("mr_cnt", bubble_cnt, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("mr_post_stall", stall_out, 0);
    step();
    check("mr_post_rd", ex_rd, 6);

    // saturate with flushes
    flush = 1'b1;
    id_valid = 1'b1;
    for (int i = 0; i < 65535; i++) @(posedge clk);
    @(negedge clk);
    check("sat_full", bubble_cnt, 16'hFFFF);
    step();
    check("sat_hold", bubble_cnt, 16'hFFFF);
    flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
